// File: rtl/bird_motion_engine_pkg.sv
// Shared definitions for the bird motion engine.
// - state_t : one-hot FSM encoding (INITIAL / FLIGHT / STOP)
// - DEF_SCREEN_W / DEF_SCREEN_H : default visible screen size in pixels
package bird_motion_engine_pkg;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    // Integer bits of the fixed-point position (sign + 10 pixel bits)
    localparam int POS_INT_W = 11;

    typedef enum logic [2:0] {
        S_INITIAL = 3'b001,
        S_FLIGHT  = 3'b010,
        S_STOP    = 3'b100
    } state_t;

endpackage

// File: rtl/bird_motion_engine_if.sv
// Control and sprite-output bundle of the bird motion engine.
// Inputs to the engine: Start, Ack, Stop, Tick, BtnPress.
// Outputs from the engine: Bird_X_L/_R, Bird_Y_T/_B, Velocity,
// Hit_Floor, Hit_Ceiling, q_Initial/q_Flight/q_Stop.
// master = controller / game side, slave = motion engine.
interface bird_motion_engine_if #(
    parameter int VEL_W = 10
);
    logic                    Start;
    logic                    Ack;
    logic                    Stop;
    logic                    Tick;
    logic                    BtnPress;
    logic [9:0]              Bird_X_L;
    logic [9:0]              Bird_X_R;
    logic [9:0]              Bird_Y_T;
    logic [9:0]              Bird_Y_B;
    logic signed [VEL_W-1:0] Velocity;
    logic                    Hit_Floor;
    logic                    Hit_Ceiling;
    logic                    q_Initial;
    logic                    q_Flight;
    logic                    q_Stop;

    modport master (
        output Start, Ack, Stop, Tick, BtnPress,
        input  Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B, Velocity,
               Hit_Floor, Hit_Ceiling, q_Initial, q_Flight, q_Stop
    );

    modport slave (
        input  Start, Ack, Stop, Tick, BtnPress,
        output Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B, Velocity,
               Hit_Floor, Hit_Ceiling, q_Initial, q_Flight, q_Stop
    );
endinterface

// File: rtl/bird_motion_engine_btn_edge_latch.sv
// Flap button edge detector with a sticky pending flag.
// Ports: Clk, reset (async, active-high), BtnPress (debounced level),
//        Consume (clears the flag), Pending (flag OR an edge this cycle).
// A rising edge arriving in the same cycle as Consume is still reported
// through Pending, so the consumer sees it and the flag stays clear.
module btn_edge_latch (
    input  logic Clk,
    input  logic reset,
    input  logic BtnPress,
    input  logic Consume,
    output logic Pending
);
    logic btn_q;
    logic flag;
    logic rise;

    assign rise    = BtnPress & ~btn_q;
    assign Pending = flag | rise;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            btn_q <= 1'b0;
            flag  <= 1'b0;
        end else begin
            btn_q <= BtnPress;
            flag  <= Consume ? 1'b0 : (flag | rise);
        end
    end
endmodule

// File: rtl/bird_motion_engine.sv
// Vertical-motion engine for the player sprite.
// Ports: Clk, reset (async, active-high), bus (bird_motion_engine_if.slave):
//   Start/Ack/Stop drive the INITIAL->FLIGHT->STOP->INITIAL FSM, Tick is the
//   frame strobe, BtnPress the flap button; outputs are the sprite box,
//   signed fixed-point Velocity, floor/ceiling hit pulses and one-hot state.
// Position and velocity advance only on Tick (semi-implicit Euler).
module bird_motion_engine
    import bird_motion_engine_pkg::*;
#(
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int BIRD_X     = 300,
    parameter int BIRD_W     = 20,
    parameter int BIRD_H     = 20,
    parameter int Y_START    = 220,
    parameter int FRAC       = 4,
    parameter int VEL_W      = 10,
    parameter int GRAVITY    = 3,
    parameter int JUMP_VEL   = 48,
    parameter int TERM_VEL   = 96,
    parameter int FLOOR_STOP = 1
) (
    input  logic                  Clk,
    input  logic                  reset,
    bird_motion_engine_if.slave   bus
);
    localparam int P_W = FRAC + POS_INT_W;

    localparam logic signed [P_W-1:0] GRAV_P    = P_W'(GRAVITY);
    localparam logic signed [P_W-1:0] JUMP_P    = P_W'(JUMP_VEL);
    localparam logic signed [P_W-1:0] TERM_P    = P_W'(TERM_VEL);
    localparam logic signed [P_W-1:0] FLOOR_P   = P_W'((SCREEN_H - BIRD_H) << FRAC);
    localparam logic signed [P_W-1:0] POS_START = P_W'(Y_START << FRAC);

    state_t                  state, state_nxt;
    logic signed [P_W-1:0]   pos, pos_nxt;
    logic signed [VEL_W-1:0] vel, vel_nxt;
    logic [9:0]              y_t, y_t_nxt, y_b;
    logic                    hit_floor, hit_floor_nxt;
    logic                    hit_ceiling, hit_ceiling_nxt;
    logic signed [P_W-1:0]   v_ext, v_try, v_new, p_new;
    logic                    pending;
    logic                    consume;

    btn_edge_latch u_btn (
        .Clk      (Clk),
        .reset    (reset),
        .BtnPress (bus.BtnPress),
        .Consume  (consume),
        .Pending  (pending)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= S_INITIAL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        pos_nxt         = pos;
        vel_nxt         = vel;
        y_t_nxt         = y_t;
        hit_floor_nxt   = 1'b0;
        hit_ceiling_nxt = 1'b0;
        consume         = 1'b1;

        // Candidate update, evaluated every cycle and used only on a Tick
        v_ext = {{(P_W-VEL_W){vel[VEL_W-1]}}, vel};
        v_try = v_ext + GRAV_P;
        if (pending)              v_new = -JUMP_P;
        else if (v_try > TERM_P)  v_new = TERM_P;
        else                      v_new = v_try;
        if (v_new < -TERM_P)      v_new = -TERM_P;
        p_new = pos + v_new;

        case (state)
            S_INITIAL: begin
                if (bus.Start) state_nxt = S_FLIGHT;
            end
            S_FLIGHT: begin
                consume = 1'b0;
                if (bus.Stop) begin
                    state_nxt = S_STOP;
                    consume   = 1'b1;
                end else if (bus.Tick) begin
                    consume = 1'b1;
                    if (p_new[P_W-1]) begin
                        pos_nxt         = '0;
                        vel_nxt         = '0;
                        hit_ceiling_nxt = 1'b1;
                    end else if (p_new >= FLOOR_P) begin
                        pos_nxt       = FLOOR_P;
                        vel_nxt       = '0;
                        hit_floor_nxt = 1'b1;
                        if (FLOOR_STOP != 0) state_nxt = S_STOP;
                    end else begin
                        pos_nxt = p_new;
                        vel_nxt = VEL_W'(v_new);
                    end
                    y_t_nxt = pos_nxt[FRAC+9:FRAC];
                end
            end
            S_STOP: begin
                if (bus.Ack) state_nxt = S_INITIAL;
            end
            default: state_nxt = S_INITIAL;
        endcase

        // Any path into (or staying in) INITIAL reloads the start position,
        // so Ack and illegal-state recovery present reset values immediately.
        if (state_nxt == S_INITIAL) begin
            pos_nxt = POS_START;
            vel_nxt = '0;
            y_t_nxt = 10'(Y_START);
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            pos         <= POS_START;
            vel         <= '0;
            y_t         <= 10'(Y_START);
            y_b         <= 10'(Y_START + BIRD_H);
            hit_floor   <= 1'b0;
            hit_ceiling <= 1'b0;
        end else begin
            pos         <= pos_nxt;
            vel         <= vel_nxt;
            y_t         <= y_t_nxt;
            y_b         <= y_t_nxt + 10'(BIRD_H);
            hit_floor   <= hit_floor_nxt;
            hit_ceiling <= hit_ceiling_nxt;
        end
    end

    assign bus.Bird_X_L    = 10'(BIRD_X);
    assign bus.Bird_X_R    = 10'(BIRD_X + BIRD_W);
    assign bus.Bird_Y_T    = y_t;
    assign bus.Bird_Y_B    = y_b;
    assign bus.Velocity    = vel;
    assign bus.Hit_Floor   = hit_floor;
    assign bus.Hit_Ceiling = hit_ceiling;
    assign bus.q_Initial   = (state == S_INITIAL);
    assign bus.q_Flight    = (state == S_FLIGHT);
    assign bus.q_Stop      = (state == S_STOP);
endmodule
